// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage MIPS core.
// Performs EX-stage operand forwarding, detects load-use hazards in ID and
// inserts LU_BUBBLES bubbles, squashes wrong-path instructions on a taken
// branch, and keeps a saturating count of ID-stall cycles.
//
// Ports:
//   clk, rst              pipeline clock, asynchronous active-high reset
//   reg_write_mem, rd_mem MEM-stage write enable / destination
//   reg_write_wb, rd_wb   WB-stage write enable / destination
//   rs_ex                 EX source addresses, operand i at [i*AW +: AW]
//   reg_write_ex          EX-stage write enable
//   mem_read_ex           EX-stage instruction is a load
//   rd_ex                 EX-stage destination
//   rs_id, use_id         ID source addresses and per-operand read flags
//   branch_taken_ex       taken branch/jump resolved in EX
//   clr_cnt               synchronous clear of stall_cnt
//   fwd_ex                per-operand forward select, [i*2 +: 2]
//   stall_if, stall_id    hold PC / hold IF/ID
//   flush_id, flush_ex    clear IF/ID / inject NOP into ID/EX
//   stall_cnt             saturating count of cycles with stall_id=1
module hazard_ctrl #(
  parameter int unsigned AW         = 5,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned LU_BUBBLES = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   reg_write_mem,
  input  logic [AW-1:0]          rd_mem,
  input  logic                   reg_write_wb,
  input  logic [AW-1:0]          rd_wb,
  input  logic [NUM_SRC*AW-1:0]  rs_ex,
  input  logic                   reg_write_ex,
  input  logic                   mem_read_ex,
  input  logic [AW-1:0]          rd_ex,
  input  logic [NUM_SRC*AW-1:0]  rs_id,
  input  logic [NUM_SRC-1:0]     use_id,
  input  logic                   branch_taken_ex,
  input  logic                   clr_cnt,
  output logic [NUM_SRC*2-1:0]   fwd_ex,
  output logic                   stall_if,
  output logic                   stall_id,
  output logic                   flush_id,
  output logic                   flush_ex,
  output logic [CNT_W-1:0]       stall_cnt
);

  localparam int unsigned BW = $clog2(LU_BUBBLES + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic [BW-1:0] bub_cnt;
  logic [BW-1:0] bub_nxt;
  logic          lu_hit;
  logic          lu;

  // Forwarding select per operand; MEM (newer) beats WB, r0 never forwarded.
  always_comb begin
    fwd_ex = '0;
    if (!rst) begin
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        if (reg_write_mem && (rd_mem != '0) && (rd_mem == rs_ex[i*AW +: AW]))
          fwd_ex[i*2 +: 2] = 2'b10;
        else if (reg_write_wb && (rd_wb != '0) && (rd_wb == rs_ex[i*AW +: AW]))
          fwd_ex[i*2 +: 2] = 2'b01;
      end
    end
  end

  // Load-use detect: EX load targets a register that ID actually reads.
  always_comb begin
    lu_hit = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (use_id[i] && (rs_id[i*AW +: AW] == rd_ex))
        lu_hit = 1'b1;
    end
    lu = mem_read_ex && reg_write_ex && (rd_ex != '0) && lu_hit;
  end

  // State register and bubble down-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bub_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bub_cnt <= bub_nxt;
    end
  end

  // Next-state and stall/flush controls; a taken branch always wins over stalls.
  always_comb begin
    state_nxt = state;
    bub_nxt   = bub_cnt;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    case (state)
      IDLE: begin
        if (branch_taken_ex) begin
          flush_id = 1'b1;
          flush_ex = 1'b1;
        end else if (lu) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
          if (LU_BUBBLES > 1) begin
            state_nxt = HOLD;
            bub_nxt   = BW'(LU_BUBBLES - 1);
          end
        end
      end
      HOLD: begin
        if (branch_taken_ex) begin
          flush_id  = 1'b1;
          flush_ex  = 1'b1;
          state_nxt = IDLE;
          bub_nxt   = '0;
        end else begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
          bub_nxt  = bub_cnt - BW'(1);
          if (bub_cnt == BW'(1))
            state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        bub_nxt   = '0;
      end
    endcase
    // Reset forces every control low regardless of the inputs.
    if (rst) begin
      stall_if = 1'b0;
      stall_id = 1'b0;
      flush_id = 1'b0;
      flush_ex = 1'b0;
    end
  end

  // Saturating stall-cycle counter; clear beats increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (clr_cnt)
      stall_cnt <= '0;
    else if (stall_id && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule
